// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pkg
// Purpose  : Shared defaults and FSM state encoding for the GCD operand
//            dispatcher and its pair queue.
// Contents : c_W_DEF      - default operand width
//            c_DEPTH_DEF  - default queue depth (power of two)
//            gcd_state_t  - dispatcher state encoding {IDLE, ISSUE, WAIT}
// Revision : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    localparam int c_W_DEF     = 4;
    localparam int c_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } gcd_state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pair_fifo
// Purpose  : Circular queue of (x, y) operand pairs with occupancy count.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            i_push, i_push_x, i_push_y - write a pair at the tail
//            i_pop           - drop the head entry
//            o_full, o_empty - occupancy flags
//            o_count         - number of stored entries (0..DEPTH)
//            o_head_x/y      - head entry contents
// Revision : 1.0 - initial release
// ============================================================================
module gcd_pair_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_x,
    input  logic [W-1:0]             i_push_y,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [W-1:0]             o_head_x,
    output logic [W-1:0]             o_head_y
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem_x [DEPTH];
    logic [W-1:0]  r_mem_y [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Guard against overflow/underflow so callers can never corrupt state.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    // Storage is intentionally left without reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= i_push_x;
            r_mem_y[r_wr_ptr] <= i_push_y;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head_x = r_mem_x[r_rd_ptr];
    assign o_head_y = r_mem_y[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/gcd_operand_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : gcd_operand_dispatch
// Purpose  : Queues nonzero operand pairs and hands them one at a time to a
//            GCD core using a start/done handshake.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            in_valid/in_ready    - upstream pair handshake, in_x/in_y data
//            gcd_start            - one-cycle start pulse to the core
//            gcd_x/gcd_y          - operands held stable for the core
//            gcd_done             - core completion pulse
//            busy                 - a pair is issued and not yet completed
//            count                - queued pairs including the in-flight one
//            drop_err             - pulse: a zero-operand pair was rejected
// Revision : 1.0 - initial release
// ============================================================================
module gcd_operand_dispatch
    import gcd_pkg::*;
#(
    parameter int W     = c_W_DEF,
    parameter int DEPTH = c_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_x,
    input  logic [W-1:0]             in_y,
    output logic                     gcd_start,
    output logic [W-1:0]             gcd_x,
    output logic [W-1:0]             gcd_y,
    input  logic                     gcd_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    gcd_state_t   r_state;
    gcd_state_t   w_state_nxt;
    logic         w_handshake;
    logic         w_zero_op;
    logic         w_push;
    logic         w_pop;
    logic         w_load;
    logic         w_full;
    logic         w_empty;
    logic         r_drop_err;
    logic [W-1:0] r_gcd_x;
    logic [W-1:0] r_gcd_y;
    logic [W-1:0] w_head_x;
    logic [W-1:0] w_head_y;

    // The in-flight pair stays in the queue until done, so count < DEPTH
    // is exactly "not full".
    assign in_ready    = ~w_full;
    assign w_handshake = in_valid & in_ready;
    assign w_zero_op   = (in_x == '0) | (in_y == '0);
    assign w_push      = w_handshake & ~w_zero_op;

    gcd_pair_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .i_push   (w_push),
        .i_push_x (in_x),
        .i_push_y (in_y),
        .i_pop    (w_pop),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (count),
        .o_head_x (w_head_x),
        .o_head_y (w_head_y)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        gcd_start   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ISSUE;
                    w_load      = 1'b1;
                end
            end
            ISSUE: begin
                gcd_start   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (gcd_done) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands are captured on the IDLE->ISSUE edge so they remain stable
    // through WAIT regardless of later pushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_drop_err <= 1'b0;
            r_gcd_x    <= '0;
            r_gcd_y    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_err <= w_handshake & w_zero_op;
            if (w_load) begin
                r_gcd_x <= w_head_x;
                r_gcd_y <= w_head_y;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign drop_err = r_drop_err;
    assign gcd_x    = r_gcd_x;
    assign gcd_y    = r_gcd_y;

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_operand_dispatch
// Purpose  : Directed self-checking bench for gcd_operand_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_operand_dispatch;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic       gcd_start;
    logic [3:0] gcd_x;
    logic [3:0] gcd_y;
    logic       gcd_done;
    logic       busy;
    logic [2:0] count;
    logic       drop_err;

    int checks = 0;
    int errors = 0;

    gcd_operand_dispatch #(
        .W     (4),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .gcd_start (gcd_start),
        .gcd_x     (gcd_x),
        .gcd_y     (gcd_y),
        .gcd_done  (gcd_done),
        .busy      (busy),
        .count     (count),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] x, input logic [3:0] y);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
    endtask

    // Complete the pair in WAIT, then expect the next head to be issued.
    task automatic done_then_issue(input logic [2:0] cnt, input logic [3:0] x, input logic [3:0] y);
        gcd_done = 1'b1;
        tick();
        gcd_done = 1'b0;
        chk("pop_count", 8'(count), 8'(cnt));
        chk("pop_busy", 8'(busy), 8'd0);
        tick();
        chk("iss_start", 8'(gcd_start), 8'd1);
        chk("iss_x", 8'(gcd_x), 8'(x));
        chk("iss_y", 8'(gcd_y), 8'(y));
        tick();
        chk("wait_start", 8'(gcd_start), 8'd0);
    endtask

    logic [3:0] wrap_x [6];
    logic [3:0] wrap_y [6];

    initial begin
        wrap_x = '{4'd1, 4'd2, 4'd15, 4'd7, 4'd11, 4'd14};
        wrap_y = '{4'd1, 4'd3, 4'd15, 4'd5, 4'd13, 4'd9};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        gcd_done = 1'b0;
        tick();
        tick();
        chk("rst_ready", 8'(in_ready), 8'd1);
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_start", 8'(gcd_start), 8'd0);
        chk("rst_drop", 8'(drop_err), 8'd0);
        chk("rst_gx", 8'(gcd_x), 8'd0);
        chk("rst_gy", 8'(gcd_y), 8'd0);
        reset = 1'b0;
        tick();

        // Single pair (4,14)
        offer(4'd4, 4'd14);
        tick();
        in_valid = 1'b0;
        chk("s_count1", 8'(count), 8'd1);
        chk("s_start0", 8'(gcd_start), 8'd0);
        tick();
        chk("s_start1", 8'(gcd_start), 8'd1);
        chk("s_gx", 8'(gcd_x), 8'd4);
        chk("s_gy", 8'(gcd_y), 8'd14);
        chk("s_busy", 8'(busy), 8'd1);
        tick();
        chk("s_start_wait", 8'(gcd_start), 8'd0);
        chk("s_busy_wait", 8'(busy), 8'd1);
        tick();
        chk("s_gx_stable", 8'(gcd_x), 8'd4);
        gcd_done = 1'b1;
        tick();
        gcd_done = 1'b0;
        chk("s_count0", 8'(count), 8'd0);
        chk("s_busy0", 8'(busy), 8'd0);
        tick();
        chk("s_idle_start", 8'(gcd_start), 8'd0);

        // Zero operands are rejected
        offer(4'd0, 4'd7);
        tick();
        chk("z_drop1", 8'(drop_err), 8'd1);
        chk("z_count1", 8'(count), 8'd0);
        offer(4'd5, 4'd0);
        tick();
        in_valid = 1'b0;
        chk("z_drop2", 8'(drop_err), 8'd1);
        chk("z_count2", 8'(count), 8'd0);
        tick();
        chk("z_drop_end", 8'(drop_err), 8'd0);
        chk("z_start_a", 8'(gcd_start), 8'd0);
        tick();
        chk("z_start_b", 8'(gcd_start), 8'd0);
        chk("z_busy", 8'(busy), 8'd0);

        // Fill the queue; gcd_done during ISSUE is ignored
        offer(4'd8, 4'd4);
        tick();
        offer(4'd6, 4'd9);
        tick();
        chk("f_start", 8'(gcd_start), 8'd1);
        chk("f_gx", 8'(gcd_x), 8'd8);
        chk("f_gy", 8'(gcd_y), 8'd4);
        offer(4'd10, 4'd15);
        gcd_done = 1'b1;
        tick();
        gcd_done = 1'b0;
        chk("f_count3", 8'(count), 8'd3);
        offer(4'd12, 4'd3);
        tick();
        chk("f_count4", 8'(count), 8'd4);
        chk("f_ready0", 8'(in_ready), 8'd0);
        offer(4'd7, 4'd14);
        tick();
        tick();
        in_valid = 1'b0;
        chk("f_full_hold", 8'(count), 8'd4);
        chk("f_drop_none", 8'(drop_err), 8'd0);
        chk("f_gx_hold", 8'(gcd_x), 8'd8);
        done_then_issue(3'd3, 4'd6, 4'd9);
        done_then_issue(3'd2, 4'd10, 4'd15);
        done_then_issue(3'd1, 4'd12, 4'd3);
        gcd_done = 1'b1;
        tick();
        gcd_done = 1'b0;
        chk("f_count0", 8'(count), 8'd0);
        tick();
        tick();
        chk("f_no_fifth", 8'(gcd_start), 8'd0);
        chk("f_idle_count", 8'(count), 8'd0);

        // Push and pop on the same edge
        offer(4'd3, 4'd5);
        tick();
        offer(4'd2, 4'd7);
        tick();
        in_valid = 1'b0;
        chk("b_gx", 8'(gcd_x), 8'd3);
        chk("b_count2", 8'(count), 8'd2);
        tick();
        offer(4'd9, 4'd6);
        gcd_done = 1'b1;
        tick();
        in_valid = 1'b0;
        gcd_done = 1'b0;
        chk("b_count_same", 8'(count), 8'd2);
        chk("b_busy0", 8'(busy), 8'd0);
        tick();
        chk("b_start2", 8'(gcd_start), 8'd1);
        chk("b_gx2", 8'(gcd_x), 8'd2);
        chk("b_gy2", 8'(gcd_y), 8'd7);
        tick();
        done_then_issue(3'd1, 4'd9, 4'd6);
        gcd_done = 1'b1;
        tick();
        gcd_done = 1'b0;
        chk("b_count0", 8'(count), 8'd0);

        // Pointer wrap: six pairs one at a time
        for (int i = 0; i < 6; i++) begin
            offer(wrap_x[i], wrap_y[i]);
            tick();
            in_valid = 1'b0;
            tick();
            chk("w_start", 8'(gcd_start), 8'd1);
            chk("w_gx", 8'(gcd_x), 8'(wrap_x[i]));
            chk("w_gy", 8'(gcd_y), 8'(wrap_y[i]));
            tick();
            gcd_done = 1'b1;
            tick();
            gcd_done = 1'b0;
            chk("w_count0", 8'(count), 8'd0);
        end

        // Reset asserted mid-cycle while in WAIT with three pairs queued
        offer(4'd1, 4'd2);
        tick();
        offer(4'd3, 4'd4);
        tick();
        offer(4'd5, 4'd6);
        tick();
        offer(4'd0, 4'd1);
        tick();
        in_valid = 1'b0;
        chk("r_count3", 8'(count), 8'd3);
        chk("r_busy1", 8'(busy), 8'd1);
        chk("r_drop1", 8'(drop_err), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_async_count", 8'(count), 8'd0);
        chk("r_async_busy", 8'(busy), 8'd0);
        chk("r_async_start", 8'(gcd_start), 8'd0);
        chk("r_async_drop", 8'(drop_err), 8'd0);
        chk("r_async_gx", 8'(gcd_x), 8'd0);
        chk("r_async_gy", 8'(gcd_y), 8'd0);
        chk("r_async_ready", 8'(in_ready), 8'd1);
        tick();
        reset    = 1'b0;
        gcd_done = 1'b1;
        tick();
        gcd_done = 1'b0;
        chk("r_late_done_count", 8'(count), 8'd0);
        chk("r_late_done_busy", 8'(busy), 8'd0);
        tick();
        chk("r_late_start", 8'(gcd_start), 8'd0);
        chk("r_late_count", 8'(count), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
